// File: rtl/soc_pio_pkg.sv
// Shared definitions for the parallel I/O controller: register word addresses
// and the edge-capture mode encoding.
package soc_pio_pkg;

  localparam logic [2:0] PIO_DATA     = 3'd0;
  localparam logic [2:0] PIO_DIR      = 3'd1;
  localparam logic [2:0] PIO_IRQ_MASK = 3'd2;
  localparam logic [2:0] PIO_EDGE_CAP = 3'd3;
  localparam logic [2:0] PIO_OUTSET   = 3'd4;
  localparam logic [2:0] PIO_OUTCLR   = 3'd5;

  typedef enum int {
    EDGE_RISE = 0,
    EDGE_FALL = 1,
    EDGE_ANY  = 2
  } edge_type_e;

endpackage

// File: rtl/soc_pio_sync.sv
// Input synchroniser chain plus one history flop; produces the synchronised
// input and a single-cycle edge pulse of the selected polarity.
module soc_pio_sync
  import soc_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
  logic [WIDTH-1:0]                  prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
      prev_q  <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], pio_in};
      prev_q  <= stage_q[SYNC_STAGES-1];
    end
  end

  assign in_sync = stage_q[SYNC_STAGES-1];

  // prev_q resets low, so an input that is high at reset release shows as a rise.
  generate
    if (EDGE_TYPE == int'(EDGE_FALL)) begin : g_fall
      assign edge_pulse = ~in_sync & prev_q;
    end else if (EDGE_TYPE == int'(EDGE_ANY)) begin : g_any
      assign edge_pulse = in_sync ^ prev_q;
    end else begin : g_rise
      assign edge_pulse = in_sync & ~prev_q;
    end
  endgenerate

endmodule

// File: rtl/soc_pio_ctrl.sv
// Avalon-MM parallel I/O slave: data/direction registers with atomic set and
// clear, synchronised inputs, W1C edge capture and a maskable level interrupt.
module soc_pio_ctrl
  import soc_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_out,
  output logic [WIDTH-1:0] pio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] in_sync, edge_pulse;
  logic [WIDTH-1:0] wd, rd;
  logic             wr;
  logic             unused_wd;

  assign wr        = chipselect && !write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  soc_pio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .pio_in    (pio_in),
    .in_sync   (in_sync),
    .edge_pulse(edge_pulse)
  );

  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    cap_d  = cap_q;
    if (wr) begin
      case (address)
        PIO_DATA:     data_d = wd;
        PIO_DIR:      dir_d  = wd;
        PIO_IRQ_MASK: mask_d = wd;
        PIO_EDGE_CAP: cap_d  = cap_q & ~wd;
        PIO_OUTSET:   data_d = data_q | wd;
        PIO_OUTCLR:   data_d = data_q & ~wd;
        default:      ;
      endcase
    end
    // A fresh edge outranks a same-cycle clear so no event is ever lost.
    cap_d = cap_d | edge_pulse;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      dir_q  <= DIR_RESET;
      mask_q <= '0;
      cap_q  <= '0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
    end
  end

  always_comb begin
    rd = '0;
    case (address)
      PIO_DATA:     rd = (data_q & dir_q) | (in_sync & ~dir_q);
      PIO_DIR:      rd = dir_q;
      PIO_IRQ_MASK: rd = mask_q;
      PIO_EDGE_CAP: rd = cap_q;
      default:      rd = '0;
    endcase
    readdata            = '0;
    readdata[WIDTH-1:0] = rd;
  end

  assign pio_out = data_q;
  assign pio_oe  = dir_q;
  assign irq     = |(cap_q & mask_q);

endmodule

// File: tb/tb_soc_pio_ctrl.sv
// Directed bench for soc_pio_ctrl with a register-level reference model that
// is compared against the DUT outputs on every falling clock edge.
module tb_soc_pio_ctrl;

  localparam int         W      = 8;
  localparam logic [7:0] RV     = 8'hA5;
  localparam logic [7:0] DR     = 8'h0F;
  localparam int         EDGE_T = 0;
  localparam int         SYNC   = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  pio_in = 8'h00;
  logic [7:0]  pio_out;
  logic [7:0]  pio_oe;
  logic        irq;

  int passed = 0;
  int total  = 0;
  logic check_en = 1'b0;

  soc_pio_ctrl #(
    .WIDTH(W), .RESET_VALUE(RV), .DIR_RESET(DR), .EDGE_TYPE(EDGE_T), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .pio_in(pio_in), .pio_out(pio_out), .pio_oe(pio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: registers as the programmer sees them; the input is seen
  // SYNC clocks late and edges compare that view with the one a clock older.
  logic [7:0] m_out, m_dir, m_mask, m_cap;
  logic [7:0] hist [0:4];
  logic [7:0] m_seen, m_older, m_edges, m_wd;
  logic [31:0] m_rd;
  logic        m_wr;

  always_comb begin
    m_seen  = hist[SYNC-1];
    m_older = hist[SYNC];
    m_wr    = chipselect && !write_n;
    m_wd    = writedata[7:0];
    case (EDGE_T)
      1:       m_edges = ~m_seen & m_older;
      2:       m_edges = m_seen ^ m_older;
      default: m_edges = m_seen & ~m_older;
    endcase
    m_rd = 32'h0;
    case (int'(address))
      0: m_rd = {24'h0, (m_out & m_dir) | (m_seen & ~m_dir)};
      1: m_rd = {24'h0, m_dir};
      2: m_rd = {24'h0, m_mask};
      3: m_rd = {24'h0, m_cap};
      default: m_rd = 32'h0;
    endcase
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_out  <= RV;
      m_dir  <= DR;
      m_mask <= 8'h00;
      m_cap  <= 8'h00;
      for (int i = 0; i < 5; i++) hist[i] <= 8'h00;
    end else begin
      m_cap <= (m_wr && int'(address) == 3) ? ((m_cap & ~m_wd) | m_edges) : (m_cap | m_edges);
      if (m_wr) begin
        case (int'(address))
          0: m_out  <= m_wd;
          1: m_dir  <= m_wd;
          2: m_mask <= m_wd;
          4: m_out  <= m_out | m_wd;
          5: m_out  <= m_out & ~m_wd;
          default: ;
        endcase
      end
      hist[0] <= pio_in;
      for (int i = 1; i < 5; i++) hist[i] <= hist[i-1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_pio_out", {24'h0, pio_out}, {24'h0, m_out});
      chk("model_pio_oe", {24'h0, pio_oe}, {24'h0, m_dir});
      chk("model_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
      chk("model_readdata", readdata, m_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("write addr=%0d data=%h -> pio_out=%h pio_oe=%h irq=%b", a, d, pio_out, pio_oe, irq);
  endtask

  initial begin
    tick();
    check_en = 1'b1;
    ticks(2);
    chk("reset_pio_out", {24'h0, pio_out}, 32'h0000_00A5);
    chk("reset_pio_oe", {24'h0, pio_oe}, 32'h0000_000F);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
    ticks(2);
    address = 3'd7;
    #1;
    chk("reserved_read", readdata, 32'h0);

    wr(3'd0, 32'h0000_003C);
    chk("data_write", {24'h0, pio_out}, 32'h0000_003C);
    wr(3'd4, 32'h0000_0001);
    chk("outset", {24'h0, pio_out}, 32'h0000_003D);
    wr(3'd5, 32'h0000_0030);
    chk("outclr", {24'h0, pio_out}, 32'h0000_000D);
    address = 3'd4;
    #1;
    chk("outset_reads0", readdata, 32'h0);
    wr(3'd6, 32'hFFFF_FFFF);
    chk("reserved_write_ignored", {24'h0, pio_out}, 32'h0000_000D);

    wr(3'd1, 32'h0000_00F0);
    chk("dir_write", {24'h0, pio_oe}, 32'h0000_00F0);
    pio_in = 8'h5A;
    ticks(3);
    address = 3'd0;
    #1;
    chk("data_mixed_read", readdata, 32'h0000_000A);

    // Clear the edges caused by 00->5A, then arm bit 2 only.
    wr(3'd3, 32'h0000_00FF);
    wr(3'd2, 32'h0000_0004);
    address = 3'd3;
    ticks(2);
    chk("edge_cap_cleared", readdata, 32'h0);
    pio_in = 8'h5E;
    ticks(2);
    chk("irq_not_yet", {31'h0, irq}, 32'h0);
    tick();
    chk("irq_after_3", {31'h0, irq}, 32'h1);
    chk("edge_cap_bit2", readdata, 32'h0000_0004);
    wr(3'd3, 32'h0000_0004);
    chk("w1c_irq_drop", {31'h0, irq}, 32'h0);
    address = 3'd3;
    #1;
    chk("w1c_cap_zero", readdata, 32'h0);

    // Re-arm bit 2, fall, then rise exactly as a W1C of bit 2 lands.
    pio_in = 8'h5A;
    ticks(4);
    pio_in = 8'h5E;
    ticks(4);
    chk("rearm_irq", {31'h0, irq}, 32'h1);
    pio_in = 8'h5A;
    ticks(4);
    pio_in = 8'h5E;
    ticks(2);
    wr(3'd3, 32'h0000_0004);
    address = 3'd3;
    #1;
    chk("set_wins_cap", readdata, 32'h0000_0004);
    chk("set_wins_irq", {31'h0, irq}, 32'h1);
    tick();
    chk("set_wins_hold", {31'h0, irq}, 32'h1);

    // Fill edge_cap with all ones and unmask everything, then reset mid-cycle.
    wr(3'd2, 32'h0000_00FF);
    pio_in = 8'h00;
    ticks(4);
    pio_in = 8'hFF;
    ticks(4);
    address = 3'd3;
    #1;
    chk("cap_all", readdata, 32'h0000_00FF);
    chk("irq_all", {31'h0, irq}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_irq", {31'h0, irq}, 32'h0);
    chk("async_pio_out", {24'h0, pio_out}, 32'h0000_00A5);
    chk("async_pio_oe", {24'h0, pio_oe}, 32'h0000_000F);
    chk("async_cap", readdata, 32'h0);
    address = 3'd2;
    #1;
    chk("async_mask", readdata, 32'h0);
    ticks(2);
    reset_n = 1'b1;
    address = 3'd3;
    ticks(2);
    chk("post_reset_no_edge_yet", readdata, 32'h0);
    tick();
    chk("post_reset_rise_seen", readdata, 32'h0000_00FF);
    chk("post_reset_irq_masked", {31'h0, irq}, 32'h0);
    ticks(3);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
